// File: rtl/row_clear_unit.sv
// Line-clear engine: checks the four rows under a landed piece, then compacts the
// board RAM bottom-up in place, zero-fills the vacated top rows and pulses clear_done.
module row_clear_unit #(
    parameter int ROWS = 16,
    parameter int COLS = 10,
    parameter int AW   = 4
) (
    input  logic            clka,
    input  logic            restart,
    input  logic            start_clear,
    input  logic [AW-1:0]   land_row,
    output logic            busy,
    output logic            clear_done,
    output logic [3:0]      which_row,
    output logic [2:0]      lines_cleared,
    output logic [AW-1:0]   rd_addr,
    input  logic [COLS-1:0] rd_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [COLS-1:0] wr_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        COMPACT = 3'd2,
        FILL    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [AW:0] LAST_ROW = (AW+1)'(ROWS - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   base;
    logic [2:0]      cnt;
    logic [3:0]      mask, mask_upd;
    logic [AW:0]     src, dst;
    logic [3:0]      which_q;
    logic [2:0]      lines_q;

    logic [AW:0]     base_ext, chk_addr, win_top, top_row;
    logic            chk_in_range, row_full, src_in_win, src_skip;
    logic [1:0]      src_idx;
    logic [2:0]      lines_nxt;

    // Addresses carry one extra bit so window rows past the board bottom stay distinguishable.
    assign base_ext     = {1'b0, base};
    assign chk_addr     = base_ext + {{(AW-1){1'b0}}, cnt[2:1]};
    assign chk_in_range = (chk_addr <= LAST_ROW);
    assign row_full     = (rd_data == {COLS{1'b1}});
    assign win_top      = base_ext + (AW+1)'(3);
    assign top_row      = (win_top > LAST_ROW) ? LAST_ROW : win_top;
    assign src_in_win   = (src >= base_ext) && (src <= win_top);
    assign src_idx      = 2'(src - base_ext);
    assign src_skip     = src_in_win && mask[src_idx];

    always_comb begin
        mask_upd = mask;
        if (cnt[0]) begin
            mask_upd[cnt[2:1]] = chk_in_range && row_full;
        end
    end

    assign lines_nxt = {2'b00, mask_upd[0]} + {2'b00, mask_upd[1]}
                     + {2'b00, mask_upd[2]} + {2'b00, mask_upd[3]};

    always_ff @(posedge clka) begin
        if (restart) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        clear_done = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        case (state)
            IDLE: begin
                if (start_clear) state_nxt = CHECK;
            end
            CHECK: begin
                if (!cnt[0] && chk_in_range) rd_addr = chk_addr[AW-1:0];
                if (cnt == 3'd7) state_nxt = (mask_upd == 4'd0) ? DONE : COMPACT;
            end
            COMPACT: begin
                if (src_skip) begin
                    if (src == '0) state_nxt = FILL;
                end else if (!cnt[0]) begin
                    rd_addr = src[AW-1:0];
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = dst[AW-1:0];
                    wr_data = rd_data;
                    if (src == '0) state_nxt = FILL;
                end
            end
            FILL: begin
                wr_en   = 1'b1;
                wr_addr = dst[AW-1:0];
                if (dst == '0) state_nxt = DONE;
            end
            DONE: begin
                clear_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            base    <= '0;
            cnt     <= '0;
            mask    <= '0;
            src     <= '0;
            dst     <= '0;
            which_q <= '0;
            lines_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_clear) begin
                        base    <= land_row;
                        cnt     <= '0;
                        mask    <= '0;
                        which_q <= '0;
                        lines_q <= '0;
                    end
                end
                CHECK: begin
                    cnt  <= cnt + 3'd1;
                    mask <= mask_upd;
                    if (cnt == 3'd7) begin
                        which_q <= mask_upd;
                        lines_q <= lines_nxt;
                        src     <= top_row;
                        dst     <= top_row;
                        cnt     <= '0;
                    end
                end
                COMPACT: begin
                    if (src_skip) begin
                        src <= src - 1'b1;
                    end else if (!cnt[0]) begin
                        cnt <= 3'd1;
                    end else begin
                        cnt <= '0;
                        src <= src - 1'b1;
                        dst <= dst - 1'b1;
                    end
                end
                FILL: begin
                    dst <= dst - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign which_row     = which_q;
    assign lines_cleared = lines_q;

endmodule

// File: tb/tb_row_clear_unit.sv
// Bench for row_clear_unit: board RAM model, expected-write scoreboard and a
// behavioural board model computing cleared rows and the compacted result.
module tb_row_clear_unit;

    localparam int ROWS = 16;
    localparam int COLS = 10;
    localparam int AW   = 4;
    localparam logic [COLS-1:0] FULL = {COLS{1'b1}};

    logic            clka = 1'b0;
    logic            restart;
    logic            start_clear;
    logic [AW-1:0]   land_row;
    logic            busy, clear_done, wr_en;
    logic [3:0]      which_row;
    logic [2:0]      lines_cleared;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [COLS-1:0] rd_data, wr_data;

    int errors = 0;
    int checks = 0;

    logic [COLS-1:0] mem [ROWS];
    logic [COLS-1:0] init_board [ROWS];
    logic [COLS-1:0] exp_board [ROWS];
    logic            load;
    logic [AW+COLS-1:0] exp_q [$];

    int busy_cnt, done_cnt, wr_cnt;

    row_clear_unit #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
        .clka(clka), .restart(restart), .start_clear(start_clear), .land_row(land_row),
        .busy(busy), .clear_done(clear_done), .which_row(which_row),
        .lines_cleared(lines_cleared), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clka = ~clka;

    always @(posedge clka) begin
        if (load) begin
            for (int i = 0; i < ROWS; i++) mem[i] <= init_board[i];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every RAM write must match the next expected write.
    always @(negedge clka) begin
        if (busy) busy_cnt++;
        if (clear_done) done_cnt++;
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {18'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                check("wr_addr_data", {18'd0, wr_addr, wr_data}, {18'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic load_board();
        @(posedge clka); #1 load = 1'b1;
        @(posedge clka); #1 load = 1'b0;
    endtask

    // Reference: full rows in the window are removed, rows above fall, top zero-filled.
    task automatic model(input int land, output logic [3:0] wmask, output int lines,
                         output int cycles);
        int top;
        logic [COLS-1:0] keep [$];
        wmask = 4'd0;
        for (int k = 0; k < 4; k++)
            if (land + k < ROWS && init_board[land+k] == FULL) wmask[k] = 1'b1;
        lines = $countones(wmask);
        top = (land + 3 > ROWS - 1) ? ROWS - 1 : land + 3;
        for (int r = 0; r < ROWS; r++) exp_board[r] = init_board[r];
        exp_q.delete();
        if (wmask != 4'd0) begin
            for (int r = 0; r <= top; r++)
                if (!(r >= land && wmask[r-land])) keep.push_back(init_board[r]);
            for (int r = 0; r < lines; r++) exp_board[r] = '0;
            for (int r = lines; r <= top; r++) exp_board[r] = keep[r-lines];
            for (int a = top; a >= 0; a--) exp_q.push_back({AW'(a), exp_board[a]});
            cycles = 8 + lines + 2 * (top + 1 - lines) + lines + 1;
        end else begin
            cycles = 9;
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clka);
            if (clear_done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_clear(input int land);
        logic [3:0] wmask;
        int lines, cycles;
        bit seen;
        load_board();
        model(land, wmask, lines, cycles);
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0;
        @(posedge clka); #1 start_clear = 1'b1; land_row = AW'(land);
        @(posedge clka); #1 start_clear = 1'b0;
        wait_done(seen);
        @(negedge clka);
        check("which_row", {28'd0, which_row}, {28'd0, wmask});
        check("lines_cleared", {29'd0, lines_cleared}, 32'(lines));
        check("busy_cycles", 32'(busy_cnt), 32'(cycles));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("writes_left", 32'(exp_q.size()), 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        for (int r = 0; r < ROWS; r++) check("board_row", {22'd0, mem[r]}, {22'd0, exp_board[r]});
    endtask

    task automatic clear_init();
        for (int r = 0; r < ROWS; r++) init_board[r] = '0;
    endtask

    initial begin
        bit seen;
        restart = 1'b1; start_clear = 1'b0; land_row = '0; load = 1'b0;
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0;
        clear_init();
        repeat (3) @(posedge clka);
        @(negedge clka);
        check("rst_ctrl", {29'd0, busy, clear_done, wr_en}, 32'd0);
        check("rst_result", {25'd0, which_row, lines_cleared}, 32'd0);
        check("rst_addr", {18'd0, rd_addr, wr_addr, wr_data}, 32'd0);
        @(posedge clka); #1 restart = 1'b0;

        // 1: empty board, nothing to clear
        clear_init();
        run_clear(12);
        check("t1_writes", 32'(wr_cnt), 32'd0);

        // 2: two full rows at the bottom
        clear_init();
        init_board[15] = FULL; init_board[14] = FULL; init_board[13] = 10'h001;
        run_clear(12);

        // 3: four full rows
        clear_init();
        for (int r = 0; r < 12; r++) init_board[r] = COLS'(r + 1);
        for (int r = 12; r < 16; r++) init_board[r] = FULL;
        run_clear(12);

        // 4: window hangs below the board
        clear_init();
        init_board[15] = FULL; init_board[14] = 10'h155; init_board[13] = 10'h0AA;
        run_clear(14);

        // 5: restart during the third COMPACT cycle
        clear_init();
        init_board[15] = FULL; init_board[14] = FULL; init_board[13] = 10'h001;
        load_board();
        exp_q.delete();
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0;
        @(posedge clka); #1 start_clear = 1'b1; land_row = 4'd12;
        @(posedge clka); #1 start_clear = 1'b0;
        repeat (10) @(posedge clka);
        #1 restart = 1'b1;
        @(posedge clka); #1 restart = 1'b0;
        @(negedge clka);
        check("abort_ctrl", {29'd0, busy, clear_done, wr_en}, 32'd0);
        check("abort_result", {25'd0, which_row, lines_cleared}, 32'd0);
        check("abort_addr", {18'd0, rd_addr, wr_addr, wr_data}, 32'd0);
        repeat (40) @(negedge clka);
        check("abort_writes", 32'(wr_cnt), 32'd0);
        check("abort_done", 32'(done_cnt), 32'd0);
        check("abort_row15", {22'd0, mem[15]}, {22'd0, FULL});

        // 6: strobes during CHECK and on DONE are ignored
        clear_init();
        load_board();
        exp_q.delete();
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0;
        @(posedge clka); #1 start_clear = 1'b1; land_row = 4'd3;
        @(posedge clka); #1 start_clear = 1'b0;
        @(posedge clka); @(posedge clka); #1 start_clear = 1'b1;
        @(posedge clka); #1 start_clear = 1'b0;
        wait_done(seen);
        start_clear = 1'b1;
        @(posedge clka); #1 start_clear = 1'b0;
        @(negedge clka);
        check("ign_busy_cycles", 32'(busy_cnt), 32'd9);
        check("ign_done_strobe", {31'd0, busy}, 32'd0);
        init_board[5] = FULL;
        run_clear(3);

        // randomized boards and landing rows
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < ROWS; r++)
                init_board[r] = ($urandom_range(0, 2) == 0) ? FULL : COLS'($urandom_range(0, 1022));
            run_clear($urandom_range(0, ROWS - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/row_clear_unit.md
Name: row_clear_unit

Overview:
Responder to the main FSM's line-clear request. On a start_clear strobe it inspects the four board rows spanned by the just-landed piece and reports full rows on which_row (the FSM's which_row input). It then compacts the board RAM in place, shifting surviving rows down over the cleared ones and zero-filling the top. It pulses clear_done when finished. It sits between main_FSM and the board RAM.

Parameters:
ROWS, 16, board height; row 0 is the top, row ROWS-1 is the bottom.
COLS, 10, board width; one RAM word per row, bit=1 means the cell is occupied.
AW, 4, row address width (must satisfy 2^AW >= ROWS).

Ports:
clka  in  1  single system clock; all state updates on its rising edge.
restart  in  1  synchronous, active-high reset.
start_clear  in  1  one-cycle request from main_FSM; sampled only in IDLE.
land_row  in  AW  topmost row of the landed piece's 4-row bounding box; sampled with start_clear.
busy  out  1  high from the cycle after an accepted start_clear through the DONE cycle.
clear_done  out  1  one-cycle completion pulse.
which_row  out  4  bit k=1 means row land_row+k was full; held until the next accepted start_clear or restart.
lines_cleared  out  3  popcount of which_row, held with it.
rd_addr  out  AW  board RAM read address; data returns on rd_data one cycle later.
rd_data  in  COLS  board RAM read data.
wr_en  out  1  board RAM write strobe.
wr_addr  out  AW  write address.
wr_data  out  COLS  write data.

Behaviour:
- Reset (restart=1 at an edge): state=IDLE. busy, clear_done, wr_en, which_row, lines_cleared, rd_addr, wr_addr and wr_data are all 0. A reset mid-operation aborts immediately; no write occurs after the reset edge and no clear_done is issued.
- Full row: rd_data == all ones (COLS bits).
- States: IDLE, CHECK, COMPACT, FILL, DONE.
- IDLE:
  - start_clear=1 latches land_row, clears which_row and lines_cleared, then goes to CHECK.
  - start_clear while in any other state is ignored.
- CHECK:
  - Takes 2 cycles per k=0..3: issue rd_addr=land_row+k, then capture.
  - If land_row+k > ROWS-1, that row is not read and mask bit k=0; the slot still costs 2 cycles. CHECK is always 8 cycles.
  - At exit, which_row and lines_cleared are updated.
  - mask==0 goes to DONE. Otherwise go to COMPACT with src=dst=min(land_row+3, ROWS-1).
- COMPACT (src uses one extra sign bit):
  - src inside the window with its mask bit set: skip; src--, 1 cycle, no write.
  - Otherwise: read src (2 cycles), wr_en=1 with wr_addr=dst and wr_data=row data in the second cycle; then src--, dst--.
  - When src < 0, go to FILL.
- FILL: one cycle per row, wr_en=1, wr_data=0, wr_addr=dst, dst-- until dst < 0; then go to DONE.
- DONE: clear_done=1 for exactly one cycle, then IDLE. busy drops in IDLE.
- wr_en is never high in IDLE, CHECK or DONE. Rows below the window are never written.
- Exactly lines_cleared rows are zero-filled, at addresses 0..lines_cleared-1.
- A start_clear in the same cycle as the DONE pulse is ignored; it is accepted only in IDLE.

Test Plan:
1. All board rows 0, land_row=12, start_clear -> busy for 8 CHECK cycles plus 1 DONE cycle; which_row=0000, lines_cleared=0, no wr_en, one clear_done pulse.
2. Rows 14 and 15 = 0x3FF, row 13 = 0x001, all others 0, land_row=12 -> which_row=1100, lines_cleared=2. Afterwards row15=0x001, row14=0, rows 0 and 1 zero-filled, rows 14/15 each written once. The bench checks the wr_addr sequence.
3. Rows 12..15 all full, land_row=12 -> which_row=1111, lines_cleared=4. 4 skip cycles, then 12 copies (rows 11..0 to 15..4), then FILL writes rows 3..0 with 0.
4. land_row=14, row 15 full -> k=2,3 are out of range with bits 0, so which_row=0010 and row 15 receives old row 14. CHECK still takes 8 cycles.
5. restart asserted on the 3rd COMPACT cycle of scenario 2 -> the next cycle has all outputs 0 and IDLE; no further wr_en, no clear_done.
6. start_clear pulsed during CHECK, and again on the DONE cycle -> both ignored. A pulse one cycle later (IDLE) is accepted.
